// File: rtl/irq_pend_latch.sv
`timescale 1ns/1ps
// irq_pend_latch: synchronises N asynchronous request lines, latches each
// rising edge into a sticky pending bit and presents the masked vector to a
// downstream priority encoder, which acknowledges one bit per strobe.
//
// Ports:
//   clk       system clock, all flops rising-edge
//   rst_n     asynchronous active-low reset
//   req_in    [N]  asynchronous request lines (event = rising edge)
//   mask      [N]  1 hides a bit from pend_out/irq (it still latches)
//   ack            acknowledge strobe, level-sampled
//   ack_code  [CW] index of the bit to clear (encoder code output)
//   pend_out  [N]  pending & ~mask (encoder input)
//   irq            OR of pend_out
//   lost_cnt  [8]  saturating dropped-event count  (IRQ_LOST_CNT_EN only)
//   lost_clr       synchronous clear of lost_cnt    (IRQ_LOST_CNT_EN only)
//
// Build option: define IRQ_LOST_CNT_EN to add the lost-event counter.

module irq_pend_latch #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CW          = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_in,
    input  logic [N-1:0]  mask,
    input  logic          ack,
    input  logic [CW-1:0] ack_code,
    output logic [N-1:0]  pend_out,
`ifdef IRQ_LOST_CNT_EN
    output logic [7:0]    lost_cnt,
    input  logic          lost_clr,
`endif
    output logic          irq
);

    // Synchroniser chain, one N-wide vector per stage.
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] sync_last;
    logic [N-1:0] prev_q;
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= req_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // History flop starts at 0, so a line held high through reset
    // release yields exactly one event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_last;
        end
    end

    assign rise = sync_last & ~prev_q;

    // One-hot clear decode; codes >= N match no bit and are ignored.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = ack && (ack_code == CW'(i));
        end
    end

    // Set wins over clear so an event arriving with its own ack survives.
    assign pending_d = rise | (pending_q & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pend_out = pending_q & ~mask;
    assign irq      = |pend_out;

`ifdef IRQ_LOST_CNT_EN
    // An event is lost when it merges into a bit that stays pending.
    logic       lost_any;
    logic [7:0] lost_q;

    assign lost_any = |(rise & pending_q & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_q <= 8'd0;
        end else if (lost_clr) begin
            lost_q <= 8'd0;
        end else if (lost_any && (lost_q != 8'hFF)) begin
            lost_q <= lost_q + 8'd1;
        end
    end

    assign lost_cnt = lost_q;
`endif

endmodule

// File: tb/tb_irq_pend_latch.sv
`timescale 1ns/1ps
// tb_irq_pend_latch: directed and random stimulus against a reference model
// built from delayed request samples and set/clear rules.

module tb_irq_pend_latch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_in = '0;
    logic [7:0] mask = '0;
    logic       ack = 1'b0;
    logic [2:0] ack_code = '0;
    logic       lost_clr = 1'b0;
    logic [7:0] pend_out;
    logic       irq;
`ifdef IRQ_LOST_CNT_EN
    logic [7:0] lost_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    irq_pend_latch dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .mask     (mask),
        .ack      (ack),
        .ack_code (ack_code),
        .pend_out (pend_out),
`ifdef IRQ_LOST_CNT_EN
        .lost_cnt (lost_cnt),
        .lost_clr (lost_clr),
`endif
        .irq      (irq)
    );

    // Reference model: samp[d] is req_in as seen d+1 edges ago.
    // An event lands when the sample taken 2 edges back is 1 and the
    // one before it is 0 (two sync stages of latency).
    logic [7:0] samp [4];
    logic [7:0] m_pend;
    int         m_lost;

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] ev;
        logic [7:0] cl;
        if (!rst_n) begin
            for (int d = 0; d < 4; d++) samp[d] = '0;
            m_pend = '0;
            m_lost = 0;
        end else begin
            for (int d = 3; d > 0; d--) samp[d] = samp[d-1];
            samp[0] = req_in;
            ev = samp[2] & ~samp[3];
            cl = ack ? (8'd1 << ack_code) : 8'd0;
            if (lost_clr) m_lost = 0;
            else if (((ev & m_pend & ~cl) != 0) && m_lost < 255)
                m_lost = m_lost + 1;
            m_pend = ev | (m_pend & ~cl);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] hi(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic cmp_model();
        check("pend_out", int'(pend_out), int'(m_pend & ~mask));
        check("irq", int'(irq), int'((m_pend & ~mask) != 0));
`ifdef IRQ_LOST_CNT_EN
        check("lost_cnt", int'(lost_cnt), m_lost);
`endif
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cmp_model();
        end
    endtask

    task automatic ack_one(input logic [2:0] c);
        ack = 1'b1;
        ack_code = c;
        step(1);
        ack = 1'b0;
    endtask

    int acks;
    int lost0;

    initial begin
        // 1: reset and latency
        #12;
        check("rst_pend", int'(pend_out), 0);
        check("rst_irq", int'(irq), 0);
        rst_n = 1'b1;
        step(2);
        req_in = 8'h20;
        step(2);
        check("t1_early", int'(pend_out), 0);
        step(1);
        check("t1_pend", int'(pend_out), 8'h20);
        check("t1_irq", int'(irq), 1);
        req_in = 8'h00;
        step(3);
        check("t1_sticky", int'(pend_out), 8'h20);
        ack_one(3'd5);

        // 2: mask, ack, unmask
        mask = 8'h80;
        req_in = 8'h81;
        step(3);
        check("t2_masked", int'(pend_out), 8'h01);
        ack_one(3'd0);
        check("t2_clr", int'(pend_out), 8'h00);
        check("t2_irq0", int'(irq), 0);
        mask = 8'h00;
        #1;
        check("t2_unmask", int'(pend_out), 8'h80);
        cmp_model();
        ack_one(3'd7);
        req_in = 8'h00;
        step(3);

        // 3: new edge coincides with ack of the same bit
        req_in = 8'h08;
        step(3);
        req_in = 8'h00;
        step(3);
        req_in = 8'h08;
        step(2);
        lost0 = m_lost;
        ack_one(3'd3);
        check("t3_keep", int'(pend_out[3]), 1);
        check("t3_lost", m_lost, lost0);
        ack_one(3'd3);
        req_in = 8'h00;
        step(3);

        // 4: merged events and lost counter saturation
        lost_clr = 1'b1;
        step(1);
        lost_clr = 1'b0;
        req_in = 8'h04;
        step(3);
        for (int r = 0; r < 300; r++) begin
            req_in = 8'h00;
            step(2);
            req_in = 8'h04;
            step(3);
`ifdef IRQ_LOST_CNT_EN
            if (r == 0) check("t4_lost1", int'(lost_cnt), 1);
`endif
        end
        check("t4_pend", int'(pend_out), 8'h04);
`ifdef IRQ_LOST_CNT_EN
        check("t4_sat", int'(lost_cnt), 255);
`endif
        lost_clr = 1'b1;
        step(1);
        lost_clr = 1'b0;
`ifdef IRQ_LOST_CNT_EN
        check("t4_clr", int'(lost_cnt), 0);
`endif
        ack_one(3'd2);
        req_in = 8'h00;
        step(3);

        // 5: async reset mid-operation, request held through release
        req_in = 8'hFF;
        step(3);
        check("t5_all", int'(pend_out), 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_pend", int'(pend_out), 0);
        check("t5_rst_irq", int'(irq), 0);
        req_in = 8'h10;
        #2;
        rst_n = 1'b1;
        step(2);
        check("t5_early", int'(pend_out), 0);
        step(1);
        check("t5_pend", int'(pend_out), 8'h10);
        ack_one(3'd4);
        req_in = 8'h00;
        step(3);

        // random phase
        for (int c = 0; c < 600; c++) begin
            req_in   = 8'($urandom);
            mask     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ack      = ($urandom_range(0, 1) == 1);
            ack_code = 3'($urandom);
            lost_clr = ($urandom_range(0, 31) == 0);
            step(1);
        end
        ack = 1'b0;
        lost_clr = 1'b0;
        mask = 8'h00;
        req_in = 8'h00;
        step(3);
        for (int g = 0; g < 16 && irq; g++) ack_one(hi(pend_out));
        check("rnd_drain", int'(irq), 0);

        // 6: priority-encoder consumer over all nonzero patterns
        for (int p = 1; p < 256; p++) begin
            req_in = 8'h00;
            step(3);
            req_in = 8'(p);
            step(3);
            acks = 0;
            for (int g = 0; g < 20 && irq; g++) begin
                check("t6_enc", int'(hi(pend_out)), int'(hi(m_pend)));
                ack_one(hi(pend_out));
                acks++;
            end
            check("t6_acks", acks, $countones(p));
            check("t6_irq", int'(irq), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
